// File: rtl/lbus_pkg.sv
// Types shared by the local-bus arbiter and the lbus-to-AXI bridge:
// arbiter state encoding and the latched request entry.
package lbus_pkg;

   localparam int LBUS_ID_W   = 2;
   localparam int LBUS_ADDR_W = 8;
   localparam int LBUS_DATA_W = 32;
   localparam int LBUS_STRB_W = LBUS_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } lbus_arb_fsm_t;

   // One issued transaction; a zero strobe marks a read.
   typedef struct packed {
      logic [LBUS_ID_W-1:0]   id;
      logic [LBUS_STRB_W-1:0] strb;
      logic [LBUS_ADDR_W-1:0] addr;
      logic [LBUS_DATA_W-1:0] data;
   } lbus_req_t;

endpackage

// File: rtl/lbus_arbiter_if.sv
// Requester-side and slave-side signals of the local-bus arbiter.
// "master" is the arbiter's view, "slave" the view of requesters plus bridge.
interface lbus_arbiter_if
   import lbus_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int AddrW  = LBUS_ADDR_W,
   parameter int DataW  = LBUS_DATA_W,
   parameter int IdW    = LBUS_ID_W,
   parameter int StrbW  = DataW / 8
);

   logic [NumReq-1:0]       req_req;
   logic [NumReq*StrbW-1:0] req_strb;
   logic [NumReq*AddrW-1:0] req_addr;
   logic [NumReq*DataW-1:0] req_wdata;
   logic [NumReq-1:0]       req_granto;
   logic [NumReq-1:0]       req_readyo;
   logic [DataW-1:0]        req_rdatao;

   logic                    bus_reqo;
   logic [IdW-1:0]          bus_ido;
   logic [StrbW-1:0]        bus_strbo;
   logic [AddrW-1:0]        bus_addro;
   logic [DataW-1:0]        bus_wdatao;
   logic                    bus_ready;
   logic [IdW-1:0]          bus_id;
   logic [DataW-1:0]        bus_rdata;
   logic                    bus_busy;
   logic                    arb_busyo;

   modport master (
      input  req_req, req_strb, req_addr, req_wdata,
      input  bus_ready, bus_id, bus_rdata, bus_busy,
      output req_granto, req_readyo, req_rdatao,
      output bus_reqo, bus_ido, bus_strbo, bus_addro, bus_wdatao, arb_busyo
   );

   modport slave (
      output req_req, req_strb, req_addr, req_wdata,
      output bus_ready, bus_id, bus_rdata, bus_busy,
      input  req_granto, req_readyo, req_rdatao,
      input  bus_reqo, bus_ido, bus_strbo, bus_addro, bus_wdatao, arb_busyo
   );

endinterface

// File: rtl/lbus_rr_picker.sv
// Combinational winner search: first set request at or after start, wrapping.
// Tying start to zero turns it into a fixed lowest-index-wins priority picker.
module lbus_rr_picker #(
   parameter  int NumReq = 4,
   localparam int IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   start,
   output logic [IdxW-1:0]   winner,
   output logic              found
);

   always_comb begin
      // NOTE: every output gets a default before the search so no path infers a latch.
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         int idx;
         idx = (int'(start) + k) % NumReq;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter sharing one local-bus slave among NumReq requesters,
// one transaction at a time. Define LBUS_ARB_PRIO_EN for fixed priority.
module lbus_arbiter
   import lbus_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int AddrW  = LBUS_ADDR_W,
   parameter int DataW  = LBUS_DATA_W,
   parameter int IdW    = LBUS_ID_W,
   parameter int StrbW  = DataW / 8
) (
   input logic            clk,
   input logic            reset,
   lbus_arbiter_if.master bus
);

   localparam int IdxW = $clog2(NumReq);

   lbus_arb_fsm_t     state, state_nxt;
   logic [NumReq-1:0] r_grant, grant_nxt;
   lbus_req_t         r_entry, entry_nxt;
   logic [NumReq-1:0] pick_req;
   logic [IdxW-1:0]   pick_start, pick_idx;
   logic              pick_found;
   logic              in_xfer, rsp_ok;

   // A granted requester is masked so a request still held during its ready pulse is not re-issued.
   assign pick_req = bus.req_req & ~r_grant;

   lbus_rr_picker #(.NumReq(NumReq)) u_picker (
      .req    (pick_req),
      .start  (pick_start),
      .winner (pick_idx),
      .found  (pick_found)
   );

`ifdef LBUS_ARB_PRIO_EN
   assign pick_start = '0;
`else
   logic [IdxW-1:0] r_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= IdxW'(NumReq - 1);
      end else if (state == ST_IDLE && state_nxt == ST_REQ) begin
         r_last <= pick_idx;
      end
   end

   assign pick_start = (r_last == IdxW'(NumReq - 1)) ? '0 : r_last + 1'b1;
`endif

   assign in_xfer = (state == ST_REQ) || (state == ST_WAIT);
   assign rsp_ok  = bus.bus_ready && (bus.bus_id == r_entry.id);

   always_comb begin
      state_nxt = state;
      grant_nxt = r_grant;
      entry_nxt = r_entry;
      unique case (state)
         ST_IDLE: begin
            if (pick_found && !bus.bus_busy) begin
               grant_nxt           = '0;
               grant_nxt[pick_idx] = 1'b1;
               entry_nxt.id        = IdW'(pick_idx);
               entry_nxt.strb      = bus.req_strb[int'(pick_idx)*StrbW +: StrbW];
               entry_nxt.addr      = bus.req_addr[int'(pick_idx)*AddrW +: AddrW];
               entry_nxt.data      = bus.req_wdata[int'(pick_idx)*DataW +: DataW];
               state_nxt           = ST_REQ;
            end
         end
         ST_REQ:   state_nxt = rsp_ok ? ST_DRAIN : ST_WAIT;
         ST_WAIT:  if (rsp_ok) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!bus.bus_busy) begin
               grant_nxt = '0;
               state_nxt = ST_IDLE;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state   <= ST_IDLE;
         r_grant <= '0;
         r_entry <= '0;
      end else begin
         state   <= state_nxt;
         r_grant <= grant_nxt;
         r_entry <= entry_nxt;
      end
   end

   assign bus.req_granto = r_grant;
   assign bus.req_readyo = {NumReq{in_xfer && rsp_ok}} & r_grant;
   assign bus.req_rdatao = bus.bus_rdata;
   assign bus.bus_reqo   = (state == ST_REQ);
   assign bus.bus_ido    = r_entry.id;
   assign bus.bus_strbo  = r_entry.strb;
   assign bus.bus_addro  = r_entry.addr;
   assign bus.bus_wdatao = r_entry.data;
   assign bus.arb_busyo  = (state != ST_IDLE);

   // A response carrying another ID is dropped; it indicates a broken slave.
   assert property (@(posedge clk) disable iff (reset)
      (in_xfer && bus.bus_ready) |-> (bus.bus_id == r_entry.id));

endmodule

// File: tb/tb_lbus_arbiter.sv
// Scoreboard bench for lbus_arbiter: directed requests, a behavioural slave,
// and a monitor checking every issue and every completion against queues.
module tb_lbus_arbiter;

   localparam int NumReq = 4;
   localparam int AddrW  = 8;
   localparam int DataW  = 32;
   localparam int IdW    = 2;
   localparam int StrbW  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lbus_arbiter_if #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW), .IdW(IdW), .StrbW(StrbW)) bus_if ();

   lbus_arbiter #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW), .IdW(IdW), .StrbW(StrbW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      logic [StrbW-1:0] strb;
      logic [AddrW-1:0] addr;
      logic [DataW-1:0] data;
   } txn_t;

   typedef struct {
      int               idx;
      logic [StrbW-1:0] strb;
      logic [AddrW-1:0] addr;
      logic [DataW-1:0] data;
   } iss_t;

   typedef struct {
      int               idx;
      bit               is_read;
      logic [DataW-1:0] rdata;
      int               lat;
   } exp_t;

   txn_t req_q [NumReq][$];
   iss_t iss_q [$];
   exp_t exp_q [$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int raise_cyc [NumReq];
   logic ext_busy = 1'b0;
   int busy_len = 0;
   int read_lat = 3;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [NumReq-1:0] onehot(input int i);
      logic [NumReq-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int pending_reqs();
      int n = 0;
      for (int i = 0; i < NumReq; i++) n += req_q[i].size();
      return n;
   endfunction

   // Slave read model: address 0x10 holds 0xDEADBEEF, others echo the address.
   function automatic logic [DataW-1:0] slave_rd(input logic [AddrW-1:0] a);
      return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hA5A5A5, a};
   endfunction

   task automatic queue_req(input int idx, input logic [StrbW-1:0] strb,
                            input logic [AddrW-1:0] addr, input logic [DataW-1:0] data);
      txn_t t;
      t.strb = strb; t.addr = addr; t.data = data;
      req_q[idx].push_back(t);
   endtask

   task automatic push_issue(input int idx, input logic [StrbW-1:0] strb,
                             input logic [AddrW-1:0] addr, input logic [DataW-1:0] data);
      iss_t s;
      s.idx = idx; s.strb = strb; s.addr = addr; s.data = data;
      iss_q.push_back(s);
   endtask

   task automatic expect_txn(input int idx, input logic [StrbW-1:0] strb,
                             input logic [AddrW-1:0] addr, input logic [DataW-1:0] data,
                             input logic [DataW-1:0] rdata, input int lat);
      exp_t e;
      push_issue(idx, strb, addr, data);
      e.idx = idx; e.is_read = (strb == '0); e.rdata = rdata; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_granto"}, bus_if.req_granto, '0);
      check({tag, "_readyo"}, bus_if.req_readyo, '0);
      check({tag, "_rdatao"}, bus_if.req_rdatao, '0);
      check({tag, "_reqo"},   bus_if.bus_reqo,   '0);
      check({tag, "_ido"},    bus_if.bus_ido,    '0);
      check({tag, "_strbo"},  bus_if.bus_strbo,  '0);
      check({tag, "_addro"},  bus_if.bus_addro,  '0);
      check({tag, "_wdatao"}, bus_if.bus_wdatao, '0);
      check({tag, "_busyo"},  bus_if.arb_busyo,  '0);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (n < budget && (exp_q.size() != 0 || iss_q.size() != 0 || pending_reqs() != 0 ||
             bus_if.req_req != '0 || bus_if.arb_busyo || bus_if.bus_busy)) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done"}, n < budget, 1'b1);
      @(posedge clk);
      #2;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requesters: raise the next queued transaction, drop after the ready pulse.
   initial begin : driver
      txn_t t;
      bus_if.req_req   = '0;
      bus_if.req_strb  = '0;
      bus_if.req_addr  = '0;
      bus_if.req_wdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus_if.req_req = '0;
            continue;
         end
         for (int i = 0; i < NumReq; i++) begin
            if (bus_if.req_readyo[i]) bus_if.req_req[i] = 1'b0;
            if (!bus_if.req_req[i] && req_q[i].size() > 0) begin
               t = req_q[i].pop_front();
               bus_if.req_strb[i*StrbW +: StrbW]  = t.strb;
               bus_if.req_addr[i*AddrW +: AddrW]  = t.addr;
               bus_if.req_wdata[i*DataW +: DataW] = t.data;
               bus_if.req_req[i] = 1'b1;
               raise_cyc[i] = cyc;
            end
         end
      end
   end

   // Slave: writes complete in the request cycle, reads after read_lat cycles.
   initial begin : slave
      int busy_cnt;
      int rd_cnt;
      bit rd_pend;
      logic [IdW-1:0] rd_id;
      logic [DataW-1:0] rd_val;
      logic prev_busy;
      busy_cnt = 0; rd_cnt = 0; rd_pend = 0; rd_id = '0; rd_val = '0;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_id    = '0;
      bus_if.bus_rdata = '0;
      bus_if.bus_busy  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         prev_busy = bus_if.bus_busy;
         bus_if.bus_ready = 1'b0;
         bus_if.bus_rdata = '0;
         if (reset) begin
            rd_pend = 0;
            busy_cnt = 0;
            bus_if.bus_busy = ext_busy;
            continue;
         end
         if (busy_cnt > 0) busy_cnt--;
         if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               rd_pend = 0;
               bus_if.bus_ready = 1'b1;
               bus_if.bus_id    = rd_id;
               bus_if.bus_rdata = rd_val;
               busy_cnt = busy_len;
            end
         end
         if (bus_if.bus_reqo) begin
            check("no_overlap_busy", prev_busy, 1'b0);
            if (bus_if.bus_strbo != '0) begin
               bus_if.bus_ready = 1'b1;
               bus_if.bus_id    = bus_if.bus_ido;
               busy_cnt = busy_len;
            end else begin
               rd_pend = 1;
               rd_cnt  = read_lat;
               rd_id   = bus_if.bus_ido;
               rd_val  = slave_rd(bus_if.bus_addro);
            end
         end
         bus_if.bus_busy = ext_busy || rd_pend || (busy_cnt > 0);
      end
   end

   // Monitor: every issue and every completion is matched against the queues.
   initial begin : monitor
      iss_t s;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus_if.bus_reqo) begin
            if (iss_q.size() == 0) begin
               check("unexpected_issue", bus_if.bus_reqo, 1'b0);
            end else begin
               s = iss_q.pop_front();
               check("issue_id",    bus_if.bus_ido,    s.idx);
               check("issue_grant", bus_if.req_granto, onehot(s.idx));
               check("issue_strb",  bus_if.bus_strbo,  s.strb);
               check("issue_addr",  bus_if.bus_addro,  s.addr);
               check("issue_wdata", bus_if.bus_wdatao, s.data);
            end
         end
         if (!reset && bus_if.req_readyo != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", bus_if.req_readyo, '0);
            end else begin
               e = exp_q.pop_front();
               check("ready_vec",   bus_if.req_readyo, onehot(e.idx));
               check("ready_id",    bus_if.bus_ido,    e.idx);
               check("ready_grant", bus_if.req_granto, onehot(e.idx));
               check("ready_phase", bus_if.bus_reqo,   !e.is_read);
               if (e.is_read) check("read_data", bus_if.req_rdatao, e.rdata);
               if (e.lat >= 0) check("latency", cyc - raise_cyc[e.idx], e.lat);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      check_outputs_zero("rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #2;

      // All four write at once; requester 0 re-requests after its first ready.
      busy_len = 2;
`ifdef LBUS_ARB_PRIO_EN
      expect_txn(0, 4'hF, 8'h00, 32'h1000_0000, '0, -1);
      expect_txn(0, 4'h3, 8'h04, 32'h1000_0004, '0, -1);
      expect_txn(1, 4'hF, 8'h01, 32'h1111_1111, '0, -1);
      expect_txn(2, 4'h1, 8'h02, 32'h2222_2222, '0, -1);
      expect_txn(3, 4'h8, 8'h03, 32'h3333_3333, '0, -1);
`else
      expect_txn(0, 4'hF, 8'h00, 32'h1000_0000, '0, -1);
      expect_txn(1, 4'hF, 8'h01, 32'h1111_1111, '0, -1);
      expect_txn(2, 4'h1, 8'h02, 32'h2222_2222, '0, -1);
      expect_txn(3, 4'h8, 8'h03, 32'h3333_3333, '0, -1);
      expect_txn(0, 4'h3, 8'h04, 32'h1000_0004, '0, -1);
`endif
      queue_req(0, 4'hF, 8'h00, 32'h1000_0000);
      queue_req(0, 4'h3, 8'h04, 32'h1000_0004);
      queue_req(1, 4'hF, 8'h01, 32'h1111_1111);
      queue_req(2, 4'h1, 8'h02, 32'h2222_2222);
      queue_req(3, 4'h8, 8'h03, 32'h3333_3333);
      wait_done("all_four", 200);

      // Single read: ready lands 1 + 3 cycles after the raise cycle.
      busy_len = 0;
      read_lat = 3;
      expect_txn(2, 4'h0, 8'h10, 32'h0, 32'hDEAD_BEEF, 4);
      queue_req(2, 4'h0, 8'h10, 32'h0);
      wait_done("single_read", 100);

      // Write latency and drain: requester 1 waits out the 5-cycle busy.
      busy_len = 5;
      expect_txn(0, 4'hF, 8'h30, 32'h1234_5678, '0, 1);
      expect_txn(1, 4'hF, 8'h31, 32'hCAFE_F00D, '0, -1);
      queue_req(0, 4'hF, 8'h30, 32'h1234_5678);
      queue_req(1, 4'hF, 8'h31, 32'hCAFE_F00D);
      wait_done("drain", 100);

      // External busy stalls the arbiter with no grant.
      busy_len = 0;
      ext_busy = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      expect_txn(2, 4'hF, 8'h40, 32'h0BAD_CAFE, '0, -1);
      queue_req(2, 4'hF, 8'h40, 32'h0BAD_CAFE);
      repeat (6) begin
         @(negedge clk);
         check("ext_busy_reqo",  bus_if.bus_reqo,   1'b0);
         check("ext_busy_grant", bus_if.req_granto, '0);
      end
      ext_busy = 1'b0;
      wait_done("ext_busy", 50);

      // Reset while waiting on a long read, then requester 0 must win first.
      read_lat = 6;
      push_issue(1, 4'h0, 8'h20, 32'h0);
      queue_req(1, 4'h0, 8'h20, 32'h0);
      n = 0;
      while (!bus_if.bus_reqo && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_reqo_seen", bus_if.bus_reqo, 1'b1);
      @(negedge clk);
      check("wait_busyo", bus_if.arb_busyo,  1'b1);
      check("wait_reqo",  bus_if.bus_reqo,   1'b0);
      check("wait_grant", bus_if.req_granto, 4'b0010);
      #2 reset = 1'b1;
      #1;
      check_outputs_zero("rst_wait");
      iss_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      read_lat = 3;
      @(posedge clk);
      #2;
      expect_txn(0, 4'hF, 8'h50, 32'h5050_5050, '0, -1);
      expect_txn(3, 4'hF, 8'h53, 32'h5353_5353, '0, -1);
      queue_req(3, 4'hF, 8'h53, 32'h5353_5353);
      queue_req(0, 4'hF, 8'h50, 32'h5050_5050);
      wait_done("after_reset", 100);

`ifdef LBUS_ARB_PRIO_EN
      // Fixed priority: requester 1 keeps winning until it stops requesting.
      expect_txn(1, 4'hF, 8'h61, 32'h6100_0001, '0, -1);
      expect_txn(1, 4'hF, 8'h62, 32'h6100_0002, '0, -1);
      expect_txn(1, 4'hF, 8'h63, 32'h6100_0003, '0, -1);
      expect_txn(3, 4'hF, 8'h64, 32'h6300_0001, '0, -1);
      queue_req(1, 4'hF, 8'h61, 32'h6100_0001);
      queue_req(1, 4'hF, 8'h62, 32'h6100_0002);
      queue_req(1, 4'hF, 8'h63, 32'h6100_0003);
      queue_req(3, 4'hF, 8'h64, 32'h6300_0001);
      wait_done("prio", 100);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
